instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and fetch stage that drives the 10-bit instruction ROM address and registers the returned word for decode.
//  The ROM read is combinational: rom_data corresponds to rom_addr in the same cycle.
//  Folds unconditional jumps in fetch, detects halt, accepts branch redirects from execute, and supports decode stalls.
// PARAMETERS
//  ADDR_W    10    ROM address width; PC width
//  INSTR_W   10    instruction width
//  RESET_PC  0     PC value loaded on reset
//  CNT_W     16    width of issued-instruction counter
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  rom_addr       out  ADDR_W   address to ROM; equals pc at all times
//  rom_data       in   INSTR_W  ROM read data for rom_addr (same cycle)
//  stall          in   1        decode cannot accept; hold pc and IR
//  branch_taken   in   1        execute resolved a taken branch this cycle
//  branch_target  in   ADDR_W   redirect address, valid with branch_taken
//  instr_out      out  INSTR_W  registered instruction to decode
//  instr_pc       out  ADDR_W   address instr_out was fetched from
//  instr_valid    out  1        instr_out is a real issued instruction
//  halted         out  1        halt has issued; fetch stopped
//  issue_count    out  CNT_W    number of instructions issued (instr_valid pulses), saturating
// BEHAVIOUR
//  Reset (sync, high): pc=RESET_PC, instr_out=0, instr_pc=0, instr_valid=0, halted=0, issue_count=0, state=RUN.
//   Reset wins over every other input, including mid-stall or mid-halt.
//  States: RUN, HALTED. Per-cycle priority (highest first): reset, branch_taken, stall, state action.
//  branch_taken (either state): pc<=branch_target; instr_valid<=0 (flush IR); state<=RUN; halted<=0.
//   branch_taken overrides stall in the same cycle.
//  stall (no redirect): pc, instr_out, instr_pc, instr_valid, issue_count all hold.
//  RUN, no stall, no redirect, decode rom_data:
//   JUMP (rom_data[9:6]==OP_JUMP): pc<={0,rom_data[5:0]} zero-extended; instr_valid<=0.
//    The jump is consumed in fetch and never issued.
//   HALT (rom_data==HALT_WORD): instr_out<=rom_data; instr_pc<=pc; instr_valid<=1; pc holds; state<=HALTED; halted<=1.
//   other: instr_out<=rom_data; instr_pc<=pc; instr_valid<=1; pc<=pc+1.
//  HALTED, no redirect: instr_valid<=0; pc and instr_out hold; halted stays 1.
//  Latency: word at address A is on instr_out, with instr_valid=1, one cycle after pc==A (no stall).
//   Sustained throughput: 1 instruction per cycle.
//  Wrap-around: pc+1 at 2^ADDR_W-1 wraps to 0.
//  A jump targeting its own address spins with instr_valid=0; this is legal, not an error.
//  issue_count increments on each cycle where instr_valid is set to 1; it saturates at all-ones.
// STRUCTURE
//  Shared package isa_pkg holds:
//   OP_JUMP=4'b1000, HALT_WORD=10'b0010000010
//   state enum {RUN, HALTED}
//   ADDR_W/INSTR_W defaults
//  One sub-module, fetch_next_pc: combinational next-pc mux (redirect/jump/hold/inc) with wrap.
//  FSM, IR, and counter live in the top module.
// TESTING (bench pairs the unit with the 10-bit instruction ROM, copy-loop program loaded)
//  1 reset 3 cycles, release -> rom_addr=0, instr_valid=0; next cycle instr_out=ROM[0], instr_pc=0, instr_valid=1.
//  2 straight-line run 0..12, no stall -> instr_pc increments 0,1,...,12 one per cycle; issue_count=13 after word 12.
//  3 fetch ROM[13]=10'b1000000111 -> next cycle pc=7, instr_valid=0; following cycle instr_pc=7, instr_out=ROM[7].
//  4 branch_taken=1, branch_target=14 while stall=1 -> pc=14, instr_valid=0;
//    then instr_out=10'b0010000010, instr_valid=1, halted=1; afterwards instr_valid=0 and pc=14 held for 10+ cycles.
//  5 stall held 4 cycles at pc=9 -> instr_out/instr_pc/issue_count unchanged; release -> resumes with instr_pc=9.
//  6 reset asserted while HALTED, and a second case with pc=1023 (ROM[1023]=0) -> reset:
//    pc=0, halted=0; wrap case: pc goes 1023->0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants, FSM state type and decode helpers for the fetch stage.
package isa_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 10;

  // Unconditional jump opcode occupies the top four bits of the word.
  localparam logic [3:0]         OP_JUMP   = 4'b1000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 10'b0010000010;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  // True when the word is an unconditional jump that fetch consumes itself.
  function automatic logic is_jump(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4] == OP_JUMP;
  endfunction

  // True when the word is the halt instruction.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word == HALT_WORD;
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-pc selection: redirect, folded jump, hold, or increment.
module fetch_next_pc
  import isa_pkg::*;
#(
  parameter int ADDR_W = isa_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              hold,
  output logic [ADDR_W-1:0] next_pc
);

  // Priority mux; the increment wraps naturally at the top of the address space.
  always_comb begin
    next_pc = pc + ADDR_W'(1);
    if (redirect) begin
      next_pc = redirect_target;
    end else if (hold) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc = jump_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register, halt FSM and issue counter for the fetch stage.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int              ADDR_W   = isa_pkg::ADDR_W,
  parameter int              INSTR_W  = isa_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   issue_count
);

  state_t               state_reg, state_next;
  logic [ADDR_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0]   instr_reg, instr_next;
  logic [ADDR_W-1:0]    instr_pc_reg, instr_pc_next;
  logic                 valid_reg, valid_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  logic                 word_is_jump;
  logic                 word_is_halt;
  logic                 fetch_active;
  logic                 jump_sel;
  logic                 hold_sel;
  logic                 issue;
  logic [ADDR_W-1:0]    jump_target;

  assign word_is_jump = is_jump(rom_data);
  assign word_is_halt = is_halt(rom_data);

  // Fetch only acts on the ROM word when running, not stalled and not redirected.
  assign fetch_active = !branch_taken && !stall && (state_reg == RUN);
  assign jump_sel     = fetch_active && word_is_jump;
  assign issue        = fetch_active && !word_is_jump;
  assign hold_sel     = stall || (state_reg == HALTED) || (issue && word_is_halt);

  // Jump target is the low six bits, zero-extended to a full address.
  assign jump_target  = ADDR_W'(rom_data[5:0]);

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc              (pc_reg),
    .redirect        (branch_taken),
    .redirect_target (branch_target),
    .jump            (jump_sel),
    .jump_target     (jump_target),
    .hold            (hold_sel),
    .next_pc         (pc_next)
  );

  // Next-state and instruction-register decode; everything holds unless updated.
  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    valid_next    = valid_reg;
    count_next    = count_reg;
    if (branch_taken) begin
      valid_next = 1'b0;
      state_next = RUN;
    end else if (stall) begin
      valid_next = valid_reg;
    end else if (state_reg == RUN) begin
      if (word_is_jump) begin
        valid_next = 1'b0;
      end else begin
        instr_next    = rom_data;
        instr_pc_next = pc_reg;
        valid_next    = 1'b1;
        if (word_is_halt) begin
          state_next = HALTED;
        end
      end
    end else begin
      valid_next = 1'b0;
    end
    if (issue && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  // State, PC, IR and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
      valid_reg    <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      valid_reg    <= valid_next;
      count_reg    <= count_next;
    end
  end

  assign rom_addr    = pc_reg;
  assign instr_out   = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALTED);
  assign issue_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench: fetch unit paired with a combinational 1024x10 ROM model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [9:0]  rom_addr;
  logic [9:0]  rom_data;
  logic        stall;
  logic        branch_taken;
  logic [9:0]  branch_target;
  logic [9:0]  instr_out;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] issue_count;

  logic [9:0]  rom [0:1023];

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] HALT_W = 10'b0010000010;
  localparam logic [9:0] JMP7_W = 10'b1000000111;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .issue_count   (issue_count)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Copy-loop program: words 0..12 are ordinary ops, 13 jumps back to 7, 14 halts.
    for (int i = 0; i < 1024; i++) rom[i] = 10'h000;
    for (int i = 0; i < 13; i++) rom[i] = 10'h100 + 10'(i);
    rom[13] = JMP7_W;
    rom[14] = HALT_W;
    rom[1023] = 10'h000;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // 1: reset for three cycles
    repeat (3) tick();
    check("rst_addr",  32'(rom_addr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_out",   32'(instr_out), 0);
    check("rst_ipc",   32'(instr_pc), 0);
    check("rst_halt",  32'(halted), 0);
    check("rst_cnt",   32'(issue_count), 0);
    $display("reset: rom_addr=%0d valid=%0b", rom_addr, instr_valid);
    reset = 1'b0;

    // 2: straight-line run, one issue per cycle
    for (int k = 0; k < 13; k++) begin
      tick();
      check("run_ipc",   32'(instr_pc), 32'(k));
      check("run_out",   32'(instr_out), 32'(10'h100 + 10'(k)));
      check("run_valid", 32'(instr_valid), 1);
      check("run_cnt",   32'(issue_count), 32'(k + 1));
      $display("run: instr_pc=%0d instr_out=%0h cnt=%0d", instr_pc, instr_out, issue_count);
    end
    check("run_pc13", 32'(rom_addr), 13);

    // 3: jump at 13 is folded, never issued
    tick();
    check("jmp_pc",    32'(rom_addr), 7);
    check("jmp_valid", 32'(instr_valid), 0);
    check("jmp_cnt",   32'(issue_count), 13);
    $display("jump: pc=%0d valid=%0b", rom_addr, instr_valid);
    tick();
    check("jmp_ipc",   32'(instr_pc), 7);
    check("jmp_out",   32'(instr_out), 32'(10'h107));
    check("jmp_valid2",32'(instr_valid), 1);
    check("jmp_cnt2",  32'(issue_count), 14);
    $display("after jump: instr_pc=%0d instr_out=%0h", instr_pc, instr_out);
    tick();
    check("pre_stall_ipc", 32'(instr_pc), 8);
    check("pre_stall_pc",  32'(rom_addr), 9);

    // 5: stall four cycles at pc=9
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stl_pc",  32'(rom_addr), 9);
      check("stl_ipc", 32'(instr_pc), 8);
      check("stl_out", 32'(instr_out), 32'(10'h108));
      check("stl_cnt", 32'(issue_count), 15);
      $display("stall: pc=%0d instr_pc=%0d cnt=%0d", rom_addr, instr_pc, issue_count);
    end
    stall = 1'b0;
    tick();
    check("rel_ipc",   32'(instr_pc), 9);
    check("rel_valid", 32'(instr_valid), 1);
    check("rel_cnt",   32'(issue_count), 16);
    check("rel_pc",    32'(rom_addr), 10);
    $display("release: instr_pc=%0d pc=%0d", instr_pc, rom_addr);

    // 4: branch overrides stall, then halt at 14
    stall = 1'b1; branch_taken = 1'b1; branch_target = 10'd14;
    tick();
    check("br_pc",    32'(rom_addr), 14);
    check("br_valid", 32'(instr_valid), 0);
    check("br_cnt",   32'(issue_count), 16);
    $display("branch: pc=%0d valid=%0b", rom_addr, instr_valid);
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    check("hlt_out",   32'(instr_out), 32'(HALT_W));
    check("hlt_ipc",   32'(instr_pc), 14);
    check("hlt_valid", 32'(instr_valid), 1);
    check("hlt_flag",  32'(halted), 1);
    check("hlt_cnt",   32'(issue_count), 17);
    check("hlt_pc",    32'(rom_addr), 14);
    $display("halt: instr_out=%0h halted=%0b", instr_out, halted);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hld_valid", 32'(instr_valid), 0);
      check("hld_pc",    32'(rom_addr), 14);
      check("hld_flag",  32'(halted), 1);
      check("hld_cnt",   32'(issue_count), 17);
      check("hld_out",   32'(instr_out), 32'(HALT_W));
      $display("halted: pc=%0d valid=%0b", rom_addr, instr_valid);
    end

    // 6: reset while halted wins over a simultaneous branch
    reset = 1'b1; branch_taken = 1'b1; branch_target = 10'd1023;
    tick();
    check("rh_pc",    32'(rom_addr), 0);
    check("rh_halt",  32'(halted), 0);
    check("rh_valid", 32'(instr_valid), 0);
    check("rh_cnt",   32'(issue_count), 0);
    $display("reset in halt: pc=%0d halted=%0b", rom_addr, halted);

    // Wrap: redirect to 1023, ordinary word there, pc wraps to 0
    reset = 1'b0;
    tick();
    check("wr_pc", 32'(rom_addr), 1023);
    check("wr_valid", 32'(instr_valid), 0);
    branch_taken = 1'b0;
    tick();
    check("wr_pc0",   32'(rom_addr), 0);
    check("wr_ipc",   32'(instr_pc), 1023);
    check("wr_out",   32'(instr_out), 0);
    check("wr_valid2",32'(instr_valid), 1);
    check("wr_cnt",   32'(issue_count), 1);
    $display("wrap: pc=%0d instr_pc=%0d", rom_addr, instr_pc);
    tick();
    check("wr_next_ipc", 32'(instr_pc), 0);
    check("wr_next_out", 32'(instr_out), 32'(10'h100));
    check("wr_next_pc",  32'(rom_addr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
